// File: rtl/axi_wr_slave_fsm_if.sv
// AXI4 write-channel (AW/W/B) signal bundle for slave port s0.
// The slave modport is the responder side; master is the initiator side.
interface axi_wr_slave_fsm_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32
);
  logic [ID_W-1:0]   axs_s0_awid;
  logic [ADDR_W-1:0] axs_s0_awaddr;
  logic [7:0]        axs_s0_awlen;
  logic [2:0]        axs_s0_awsize;
  logic [1:0]        axs_s0_awburst;
  logic              axs_s0_awvalid;
  logic              axs_s0_awready;
  logic              axs_s0_wlast;
  logic              axs_s0_wvalid;
  logic              axs_s0_wready;
  logic [ID_W-1:0]   axs_s0_bid;
  logic [1:0]        axs_s0_bresp;
  logic              axs_s0_bvalid;
  logic              axs_s0_bready;

  modport slave (
    input  axs_s0_awid, axs_s0_awaddr, axs_s0_awlen, axs_s0_awsize, axs_s0_awburst,
    input  axs_s0_awvalid, axs_s0_wlast, axs_s0_wvalid, axs_s0_bready,
    output axs_s0_awready, axs_s0_wready, axs_s0_bid, axs_s0_bresp, axs_s0_bvalid
  );

  modport master (
    output axs_s0_awid, axs_s0_awaddr, axs_s0_awlen, axs_s0_awsize, axs_s0_awburst,
    output axs_s0_awvalid, axs_s0_wlast, axs_s0_wvalid, axs_s0_bready,
    input  axs_s0_awready, axs_s0_wready, axs_s0_bid, axs_s0_bresp, axs_s0_bvalid
  );
endinterface

// File: rtl/axi_wr_slave_fsm.sv
// AXI4 write responder for slave port s0: accepts one AW, counts W beats into the
// input FIFO by awlen, then returns a single B response (SLVERR on any wlast mismatch).
module axi_wr_slave_fsm #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  axi_wr_slave_fsm_if.slave s0,
  input  logic              in_fifo_full,
  output logic              in_fifo_push,
  output logic              in_fifo_push_last,
  output logic [ADDR_W-1:0] wr_addr
);

  typedef enum logic [3:0] {
    INIT     = 4'h1,
    AW_READY = 4'h2,
    W_DATA   = 4'h4,
    B_RESP   = 4'h8
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   awid_q, awid_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [2:0]        awsize_q, awsize_d;
  logic [1:0]        awburst_q, awburst_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;
  logic              err_q, err_d;

  logic              last_beat;
  logic              beat_accept;

  // Size and burst type are captured for downstream use but do not steer this FSM.
  logic              unused_aw_attrs;
  assign unused_aw_attrs = ^{awsize_q, awburst_q};

  assign last_beat   = (beat_cnt_q == 8'd0);
  assign beat_accept = s0.axs_s0_wvalid & ~in_fifo_full;
  assign wr_addr     = awaddr_q;

  // NOTE: every output and _d signal gets a default before the case, so no path
  // through this block leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d           = state_q;
    awid_d            = awid_q;
    awaddr_d          = awaddr_q;
    awsize_d          = awsize_q;
    awburst_d         = awburst_q;
    beat_cnt_d        = beat_cnt_q;
    err_d             = err_q;
    s0.axs_s0_awready = 1'b0;
    s0.axs_s0_wready  = 1'b0;
    s0.axs_s0_bvalid  = 1'b0;
    s0.axs_s0_bid     = '0;
    s0.axs_s0_bresp   = 2'b00;
    in_fifo_push      = 1'b0;
    in_fifo_push_last = 1'b0;

    case (state_q)
      INIT: begin
        awid_d     = '0;
        awaddr_d   = '0;
        awsize_d   = '0;
        awburst_d  = '0;
        beat_cnt_d = '0;
        err_d      = 1'b0;
        state_d    = AW_READY;
      end

      AW_READY: begin
        s0.axs_s0_awready = 1'b1;
        if (s0.axs_s0_awvalid) begin
          awid_d     = s0.axs_s0_awid;
          awaddr_d   = s0.axs_s0_awaddr;
          awsize_d   = s0.axs_s0_awsize;
          awburst_d  = s0.axs_s0_awburst;
          beat_cnt_d = s0.axs_s0_awlen;
          err_d      = 1'b0;
          state_d    = W_DATA;
        end
      end

      W_DATA: begin
        s0.axs_s0_wready = ~in_fifo_full;
        if (beat_accept) begin
          in_fifo_push      = 1'b1;
          in_fifo_push_last = last_beat;
          // The beat count decides where the burst ends; wlast only flags an error.
          if (s0.axs_s0_wlast != last_beat) err_d = 1'b1;
          if (last_beat) state_d = B_RESP;
          else           beat_cnt_d = beat_cnt_q - 8'd1;
        end
      end

      B_RESP: begin
        s0.axs_s0_bvalid = 1'b1;
        s0.axs_s0_bid    = awid_q;
        s0.axs_s0_bresp  = err_q ? 2'b10 : 2'b00;
        if (s0.axs_s0_bready) state_d = AW_READY;
      end

      default: state_d = INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= INIT;
      awid_q     <= '0;
      awaddr_q   <= '0;
      awsize_q   <= '0;
      awburst_q  <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      awid_q     <= awid_d;
      awaddr_q   <= awaddr_d;
      awsize_q   <= awsize_d;
      awburst_q  <= awburst_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_axi_wr_slave_fsm.sv
// Directed bench for axi_wr_slave_fsm: a per-cycle vector table for the basic
// write flows, plus hand sequences for stalls, B back-pressure, mid-burst reset and a 256-beat burst.
module tb_axi_wr_slave_fsm;
  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_fifo_full;
  logic              in_fifo_push;
  logic              in_fifo_push_last;
  logic [ADDR_W-1:0] wr_addr;

  int n_checks = 0;
  int n_fail   = 0;

  axi_wr_slave_fsm_if #(.ID_W(ID_W), .ADDR_W(ADDR_W)) bus ();

  axi_wr_slave_fsm #(.ID_W(ID_W), .ADDR_W(ADDR_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .s0                (bus),
    .in_fifo_full      (in_fifo_full),
    .in_fifo_push      (in_fifo_push),
    .in_fifo_push_last (in_fifo_push_last),
    .wr_addr           (wr_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        awvalid;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic        wvalid;
    logic        wlast;
    logic        bready;
    logic        full;
    logic        e_awready;
    logic        e_wready;
    logic        e_bvalid;
    logic [3:0]  e_bid;
    logic [1:0]  e_bresp;
    logic        e_push;
    logic        e_last;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(
    input logic rst, input logic awvalid, input logic [3:0] awid, input logic [31:0] awaddr,
    input logic [7:0] awlen, input logic wvalid, input logic wlast, input logic bready,
    input logic full, input logic e_awready, input logic e_wready, input logic e_bvalid,
    input logic [3:0] e_bid, input logic [1:0] e_bresp, input logic e_push, input logic e_last,
    input logic [31:0] e_addr);
    vec_t v;
    v.rst = rst; v.awvalid = awvalid; v.awid = awid; v.awaddr = awaddr; v.awlen = awlen;
    v.wvalid = wvalid; v.wlast = wlast; v.bready = bready; v.full = full;
    v.e_awready = e_awready; v.e_wready = e_wready; v.e_bvalid = e_bvalid; v.e_bid = e_bid;
    v.e_bresp = e_bresp; v.e_push = e_push; v.e_last = e_last; v.e_addr = e_addr;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " awready"}, 64'(bus.axs_s0_awready), 64'd0);
    check({tag, " wready"},  64'(bus.axs_s0_wready),  64'd0);
    check({tag, " bvalid"},  64'(bus.axs_s0_bvalid),  64'd0);
    check({tag, " bid"},     64'(bus.axs_s0_bid),     64'd0);
    check({tag, " bresp"},   64'(bus.axs_s0_bresp),   64'd0);
    check({tag, " push"},    64'(in_fifo_push),       64'd0);
    check({tag, " push_last"}, 64'(in_fifo_push_last), 64'd0);
    check({tag, " wr_addr"}, 64'(wr_addr),            64'd0);
  endtask

  // Starts in AW_READY at posedge+1; returns at posedge+1 once bvalid is seen.
  task automatic run_burst(input string tag, input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input int stall_beat, input int stall_cycles,
                           output int pushes, output int lasts, output int last_idx,
                           output int cycles);
    int stalls;
    int beat;
    logic stall;
    pushes = 0; lasts = 0; last_idx = 0; cycles = 0; stalls = 0;
    bus.axs_s0_awvalid = 1'b1;
    bus.axs_s0_awid    = id;
    bus.axs_s0_awaddr  = addr;
    bus.axs_s0_awlen   = len;
    #2;
    check({tag, " awready"}, 64'(bus.axs_s0_awready), 64'd1);
    tick();
    bus.axs_s0_awvalid = 1'b0;
    while (bus.axs_s0_bvalid !== 1'b1 && cycles < 600) begin
      beat  = pushes + 1;
      stall = (beat == stall_beat) && (stalls < stall_cycles);
      in_fifo_full       = stall;
      bus.axs_s0_wvalid  = 1'b1;
      bus.axs_s0_wlast   = (beat == int'(len) + 1);
      #2;
      if (stall) begin
        check($sformatf("%s stall%0d wready", tag, stalls), 64'(bus.axs_s0_wready), 64'd0);
        check($sformatf("%s stall%0d push", tag, stalls), 64'(in_fifo_push), 64'd0);
        stalls++;
      end
      if (in_fifo_push === 1'b1) begin
        pushes++;
        if (in_fifo_push_last === 1'b1) begin
          lasts++;
          last_idx = pushes;
        end
      end
      cycles++;
      tick();
    end
    bus.axs_s0_wvalid = 1'b0;
    bus.axs_s0_wlast  = 1'b0;
    in_fifo_full      = 1'b0;
    check({tag, " bvalid reached"}, 64'(bus.axs_s0_bvalid), 64'd1);
    check({tag, " wr_addr"}, 64'(wr_addr), 64'(addr));
  endtask

  task automatic b_finish(input string tag, input logic [3:0] id, input logic [1:0] resp);
    bus.axs_s0_bready = 1'b1;
    #2;
    check({tag, " bvalid"}, 64'(bus.axs_s0_bvalid), 64'd1);
    check({tag, " bid"},    64'(bus.axs_s0_bid),    64'(id));
    check({tag, " bresp"},  64'(bus.axs_s0_bresp),  64'(resp));
    tick();
    bus.axs_s0_bready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int pushes, lasts, last_idx, cycles;

    //            rst awv id     addr          len  wv wl br fu | awr wr bv bid   bresp  pu pl  wr_addr
    vecs[0]  = mk(1, 0, 4'd0, 32'h0,      8'd0, 0, 0, 0, 0,   0, 0, 0, 4'd0, 2'b00, 0, 0, 32'h0);
    vecs[1]  = mk(0, 0, 4'd0, 32'h0,      8'd0, 0, 0, 0, 0,   0, 0, 0, 4'd0, 2'b00, 0, 0, 32'h0);
    vecs[2]  = mk(0, 1, 4'd5, 32'h1000,   8'd0, 0, 0, 0, 0,   1, 0, 0, 4'd0, 2'b00, 0, 0, 32'h0);
    vecs[3]  = mk(0, 0, 4'd0, 32'h0,      8'd0, 1, 1, 0, 0,   0, 1, 0, 4'd0, 2'b00, 1, 1, 32'h1000);
    vecs[4]  = mk(0, 0, 4'd0, 32'h0,      8'd0, 0, 0, 1, 0,   0, 0, 1, 4'd5, 2'b00, 0, 0, 32'h1000);
    // early wlast on beat 2 of 4
    vecs[5]  = mk(0, 1, 4'd3, 32'h2000,   8'd3, 0, 0, 0, 0,   1, 0, 0, 4'd0, 2'b00, 0, 0, 32'h1000);
    vecs[6]  = mk(0, 0, 4'd0, 32'h0,      8'd0, 1, 0, 0, 0,   0, 1, 0, 4'd0, 2'b00, 1, 0, 32'h2000);
    vecs[7]  = mk(0, 0, 4'd0, 32'h0,      8'd0, 1, 1, 0, 0,   0, 1, 0, 4'd0, 2'b00, 1, 0, 32'h2000);
    vecs[8]  = mk(0, 0, 4'd0, 32'h0,      8'd0, 1, 0, 0, 0,   0, 1, 0, 4'd0, 2'b00, 1, 0, 32'h2000);
    vecs[9]  = mk(0, 0, 4'd0, 32'h0,      8'd0, 1, 1, 0, 0,   0, 1, 0, 4'd0, 2'b00, 1, 1, 32'h2000);
    vecs[10] = mk(0, 0, 4'd0, 32'h0,      8'd0, 0, 0, 1, 0,   0, 0, 1, 4'd3, 2'b10, 0, 0, 32'h2000);
    // missing wlast on beat 4 of 4
    vecs[11] = mk(0, 1, 4'd9, 32'h3000,   8'd3, 0, 0, 0, 0,   1, 0, 0, 4'd0, 2'b00, 0, 0, 32'h2000);
    vecs[12] = mk(0, 0, 4'd0, 32'h0,      8'd0, 1, 0, 0, 0,   0, 1, 0, 4'd0, 2'b00, 1, 0, 32'h3000);
    vecs[13] = mk(0, 0, 4'd0, 32'h0,      8'd0, 1, 0, 0, 0,   0, 1, 0, 4'd0, 2'b00, 1, 0, 32'h3000);
    vecs[14] = mk(0, 0, 4'd0, 32'h0,      8'd0, 1, 0, 0, 0,   0, 1, 0, 4'd0, 2'b00, 1, 0, 32'h3000);
    vecs[15] = mk(0, 0, 4'd0, 32'h0,      8'd0, 1, 0, 0, 0,   0, 1, 0, 4'd0, 2'b00, 1, 1, 32'h3000);
    vecs[16] = mk(0, 0, 4'd0, 32'h0,      8'd0, 0, 0, 1, 0,   0, 0, 1, 4'd9, 2'b10, 0, 0, 32'h3000);
    // stray wvalid in AW_READY is not accepted
    vecs[17] = mk(0, 0, 4'd0, 32'h0,      8'd0, 1, 1, 0, 0,   1, 0, 0, 4'd0, 2'b00, 0, 0, 32'h3000);

    reset = 1'b1;
    in_fifo_full = 1'b0;
    bus.axs_s0_awvalid = 1'b0; bus.axs_s0_awid = '0; bus.axs_s0_awaddr = '0;
    bus.axs_s0_awlen = '0; bus.axs_s0_awsize = 3'd2; bus.axs_s0_awburst = 2'b01;
    bus.axs_s0_wvalid = 1'b0; bus.axs_s0_wlast = 1'b0; bus.axs_s0_bready = 1'b0;
    tick();
    tick();

    for (int i = 0; i < 18; i++) begin
      reset              = vecs[i].rst;
      bus.axs_s0_awvalid = vecs[i].awvalid;
      bus.axs_s0_awid    = vecs[i].awid;
      bus.axs_s0_awaddr  = vecs[i].awaddr;
      bus.axs_s0_awlen   = vecs[i].awlen;
      bus.axs_s0_wvalid  = vecs[i].wvalid;
      bus.axs_s0_wlast   = vecs[i].wlast;
      bus.axs_s0_bready  = vecs[i].bready;
      in_fifo_full       = vecs[i].full;
      #2;
      check($sformatf("v%0d awready", i),   64'(bus.axs_s0_awready), 64'(vecs[i].e_awready));
      check($sformatf("v%0d wready", i),    64'(bus.axs_s0_wready),  64'(vecs[i].e_wready));
      check($sformatf("v%0d bvalid", i),    64'(bus.axs_s0_bvalid),  64'(vecs[i].e_bvalid));
      check($sformatf("v%0d bid", i),       64'(bus.axs_s0_bid),     64'(vecs[i].e_bid));
      check($sformatf("v%0d bresp", i),     64'(bus.axs_s0_bresp),   64'(vecs[i].e_bresp));
      check($sformatf("v%0d push", i),      64'(in_fifo_push),       64'(vecs[i].e_push));
      check($sformatf("v%0d push_last", i), 64'(in_fifo_push_last),  64'(vecs[i].e_last));
      check($sformatf("v%0d wr_addr", i),   64'(wr_addr),            64'(vecs[i].e_addr));
      tick();
    end
    bus.axs_s0_wvalid = 1'b0;
    bus.axs_s0_wlast  = 1'b0;

    // FIFO full for 3 cycles during beat 2 of a 4-beat burst
    run_burst("stall", 4'd2, 32'h4000, 8'd3, 2, 3, pushes, lasts, last_idx, cycles);
    check("stall pushes", 64'(pushes), 64'd4);
    check("stall push_last count", 64'(lasts), 64'd1);
    check("stall push_last beat", 64'(last_idx), 64'd4);
    check("stall w cycles", 64'(cycles), 64'd7);
    b_finish("stall B", 4'd2, 2'b00);

    // B back-pressure: outputs hold, pending AW ignored
    run_burst("bp", 4'hA, 32'h5000, 8'd0, 0, 0, pushes, lasts, last_idx, cycles);
    bus.axs_s0_awvalid = 1'b1;
    bus.axs_s0_awid    = 4'd1;
    bus.axs_s0_awaddr  = 32'h6000;
    bus.axs_s0_awlen   = 8'd0;
    for (int c = 0; c < 5; c++) begin
      #2;
      check($sformatf("bp hold%0d bvalid", c),  64'(bus.axs_s0_bvalid),  64'd1);
      check($sformatf("bp hold%0d bid", c),     64'(bus.axs_s0_bid),     64'hA);
      check($sformatf("bp hold%0d bresp", c),   64'(bus.axs_s0_bresp),   64'd0);
      check($sformatf("bp hold%0d awready", c), 64'(bus.axs_s0_awready), 64'd0);
      check($sformatf("bp hold%0d wr_addr", c), 64'(wr_addr),            64'h5000);
      tick();
    end
    bus.axs_s0_awvalid = 1'b0;
    b_finish("bp B", 4'hA, 2'b00);
    #2;
    check("bp awready after B", 64'(bus.axs_s0_awready), 64'd1);
    check("bp bvalid after B",  64'(bus.axs_s0_bvalid),  64'd0);
    check("bp wr_addr after B", 64'(wr_addr),            64'h5000);
    tick();

    // reset after 2 of 4 beats
    bus.axs_s0_awvalid = 1'b1;
    bus.axs_s0_awid    = 4'd7;
    bus.axs_s0_awaddr  = 32'h7000;
    bus.axs_s0_awlen   = 8'd3;
    tick();
    bus.axs_s0_awvalid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bus.axs_s0_wvalid = 1'b1;
      bus.axs_s0_wlast  = 1'b0;
      #2;
      check($sformatf("rst beat%0d push", b), 64'(in_fifo_push), 64'd1);
      tick();
    end
    reset = 1'b1;
    tick();
    check_idle("rst in reset");
    reset = 1'b0;
    bus.axs_s0_wvalid = 1'b0;
    #2;
    check_idle("rst INIT");
    tick();
    check("rst awready", 64'(bus.axs_s0_awready), 64'd1);
    check("rst bvalid",  64'(bus.axs_s0_bvalid),  64'd0);
    run_burst("post-rst", 4'd8, 32'h8000, 8'd1, 0, 0, pushes, lasts, last_idx, cycles);
    check("post-rst pushes", 64'(pushes), 64'd2);
    check("post-rst push_last beat", 64'(last_idx), 64'd2);
    b_finish("post-rst B", 4'd8, 2'b00);

    // 256-beat burst, no back-pressure
    run_burst("long", 4'hF, 32'hA000_0000, 8'd255, 0, 0, pushes, lasts, last_idx, cycles);
    check("long pushes", 64'(pushes), 64'd256);
    check("long push_last count", 64'(lasts), 64'd1);
    check("long push_last beat", 64'(last_idx), 64'd256);
    check("long w cycles", 64'(cycles), 64'd256);
    b_finish("long B", 4'hF, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
